// File: rtl/result_drain_control.sv
// Result drain: snapshots the PE accumulator bus and writes it,
// one saturated word per cycle, into the output feature-map RAM.
module result_drain_control #(
  parameter int data_size     = 16,
  parameter int acc_size      = 32,
  parameter int array_size    = 9,
  parameter int dim_data_size = 16
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      enable,
  input  logic                                      start,
  input  logic [14:0]                               initial_address,
  input  logic [dim_data_size-1:0]                  number_filters,
  input  logic [dim_data_size-1:0]                  out_cols,
  input  logic [acc_size*array_size*array_size-1:0] result_in,
  output logic [14:0]                               ram_addr,
  output logic [data_size-1:0]                      ram_din,
  output logic                                      ram_we,
  output logic                                      busy,
  output logic                                      done
);

  localparam int NE = array_size * array_size;
  localparam int SW = acc_size * NE;
  localparam int DW = dim_data_size;

  localparam logic [DW-1:0] AS  = DW'(array_size);
  localparam logic [DW-1:0] ONE = DW'(1);

  localparam logic signed [acc_size-1:0] SAT_MAX =
    acc_size'((longint'(1) <<< (data_size - 1)) - longint'(1));
  localparam logic signed [acc_size-1:0] SAT_MIN =
    acc_size'(-(longint'(1) <<< (data_size - 1)));

  localparam logic [data_size-1:0] POS_SAT =
    {1'b0, {(data_size - 1){1'b1}}};
  localparam logic [data_size-1:0] NEG_SAT =
    {1'b1, {(data_size - 1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_WRITE,
    S_FINISH
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;

  logic [SW-1:0]          r_snap;
  logic [SW-1:0]          w_snap_nxt;
  logic [14:0]            r_base;
  logic [14:0]            w_base_nxt;
  logic [DW-1:0]          r_rows;
  logic [DW-1:0]          w_rows_nxt;
  logic [DW-1:0]          r_cols;
  logic [DW-1:0]          w_cols_nxt;
  logic [DW-1:0]          r_stride;
  logic [DW-1:0]          w_stride_nxt;
  logic [DW-1:0]          r_row;
  logic [DW-1:0]          w_row_nxt;
  logic [DW-1:0]          r_col;
  logic [DW-1:0]          w_col_nxt;
  logic                   r_tail;
  logic                   w_tail_nxt;

  logic [14:0]            r_addr;
  logic [14:0]            w_addr_nxt;
  logic [data_size-1:0]   r_din;
  logic [data_size-1:0]   w_din_nxt;
  logic                   r_we;
  logic                   w_we_nxt;
  logic                   r_busy;
  logic                   w_busy_nxt;
  logic                   r_done;
  logic                   w_done_nxt;

  logic [DW-1:0]          w_rows_clamp;
  logic [DW-1:0]          w_cols_clamp;
  logic [31:0]            w_addr_full;
  int                     w_idx;
  logic signed [acc_size-1:0] w_elem;
  logic                   w_row_last;
  logic                   w_col_last;

  function automatic logic [data_size-1:0] f_sat(
    input logic signed [acc_size-1:0] x
  );
    if (x > SAT_MAX) begin
      return POS_SAT;
    end
    if (x < SAT_MIN) begin
      return NEG_SAT;
    end
    return x[data_size-1:0];
  endfunction

  // Only the first array_size rows/cols of the tile exist in the PE array.
  assign w_rows_clamp = (number_filters > AS) ? AS : number_filters;
  assign w_cols_clamp = (out_cols > AS) ? AS : out_cols;

  // Row stride is the full out_cols, so the tile lands in a wider map.
  assign w_addr_full = 32'(r_base)
                     + 32'(r_row) * 32'(r_stride)
                     + 32'(r_col);

  assign w_idx  = int'(r_row) * array_size + int'(r_col);
  assign w_elem = r_snap[w_idx*acc_size +: acc_size];

  assign w_row_last = (r_row == r_rows - ONE);
  assign w_col_last = (r_col == r_cols - ONE);

  // Next-state and next-output logic; enable low freezes everything.
  always_comb begin
    w_state_nxt  = r_state;
    w_snap_nxt   = r_snap;
    w_base_nxt   = r_base;
    w_rows_nxt   = r_rows;
    w_cols_nxt   = r_cols;
    w_stride_nxt = r_stride;
    w_row_nxt    = r_row;
    w_col_nxt    = r_col;
    w_tail_nxt   = r_tail;
    w_addr_nxt   = r_addr;
    w_din_nxt    = r_din;
    w_we_nxt     = 1'b0;
    w_busy_nxt   = r_busy;
    w_done_nxt   = r_done;
    if (enable) begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            w_snap_nxt   = result_in;
            w_base_nxt   = initial_address;
            w_rows_nxt   = w_rows_clamp;
            w_cols_nxt   = w_cols_clamp;
            w_stride_nxt = out_cols;
            w_done_nxt   = 1'b0;
            w_busy_nxt   = 1'b1;
            w_state_nxt  = S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          w_row_nxt  = '0;
          w_col_nxt  = '0;
          w_tail_nxt = 1'b0;
          if (r_rows == '0 || r_cols == '0) begin
            w_state_nxt = S_FINISH;
          end else begin
            w_state_nxt = S_WRITE;
          end
        end
        S_WRITE: begin
          if (r_tail) begin
            w_state_nxt = S_FINISH;
          end else begin
            w_we_nxt   = 1'b1;
            w_addr_nxt = w_addr_full[14:0];
            w_din_nxt  = f_sat(w_elem);
            if (w_col_last && w_row_last) begin
              w_tail_nxt = 1'b1;
            end else if (w_col_last) begin
              w_col_nxt = '0;
              w_row_nxt = r_row + ONE;
            end else begin
              w_col_nxt = r_col + ONE;
            end
          end
        end
        S_FINISH: begin
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Snapshot, counters and registered RAM-side outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_snap   <= '0;
      r_base   <= '0;
      r_rows   <= '0;
      r_cols   <= '0;
      r_stride <= '0;
      r_row    <= '0;
      r_col    <= '0;
      r_tail   <= 1'b0;
      r_addr   <= '0;
      r_din    <= '0;
      r_we     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_snap   <= w_snap_nxt;
      r_base   <= w_base_nxt;
      r_rows   <= w_rows_nxt;
      r_cols   <= w_cols_nxt;
      r_stride <= w_stride_nxt;
      r_row    <= w_row_nxt;
      r_col    <= w_col_nxt;
      r_tail   <= w_tail_nxt;
      r_addr   <= w_addr_nxt;
      r_din    <= w_din_nxt;
      r_we     <= w_we_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign ram_addr = r_addr;
  assign ram_din  = r_din;
  assign ram_we   = r_we;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule
